// File: rtl/toggle_pkg.sv
// Shared types and constants for the two-phase toggle event link.
package toggle_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/toggle_sync_chain.sv
// N-flop synchroniser for a single asynchronous level, reset to 0.
// Also serves the sender side for bringing ack_t back into its domain.
module sync_chain
  import toggle_pkg::*;
#(
  parameter int N = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Receiving end of the toggle event link: every level change on t_in
// becomes one valid/ready event; ack_t flips once per consumed event.
module toggle_event_receiver
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             ack_t,
  output logic [CNT_W-1:0] evt_count,
  output logic             overrun,
  input  logic             clr_overrun
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("toggle_event_receiver: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic             t_s;
  logic             prev_q;
  logic             edge_det;
  logic             hshk;
  state_t           state_q, state_d;
  logic             ack_q, ack_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sync_chain #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (t_in),
    .q_o   (t_s)
  );

  // prev_q resets to 0, so a line already high at reset release counts once.
  assign edge_det = t_s ^ prev_q;
  assign hshk     = (state_q == PENDING) && evt_ready;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;

    if (edge_det && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (clr_overrun) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (hshk) begin
          ack_d   = ~ack_q;
          state_d = edge_det ? PENDING : IDLE;
        end else if (edge_det) begin
          // Second event merges into the pending one; set beats clear.
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      state_q <= IDLE;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= t_s;
      state_q <= state_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign evt_valid = (state_q == PENDING);
  assign ack_t     = ack_q;
  assign overrun   = ovr_q;
  assign evt_count = cnt_q;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Bench for toggle_event_receiver: directed vector table, corner sequences,
// then random traffic against an event-level reference model.
module tb_toggle_event_receiver;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       t_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       clr_overrun = 1'b0;

  logic       v8, a8, o8;
  logic [7:0] c8;
  logic       v3, a3, o3;
  logic [2:0] c3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  toggle_event_receiver #(.SYNC_STAGES(SYNC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .t_in(t_in), .evt_valid(v8), .evt_ready(evt_ready),
    .ack_t(a8), .evt_count(c8), .overrun(o8), .clr_overrun(clr_overrun)
  );

  toggle_event_receiver #(.SYNC_STAGES(SYNC), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .t_in(t_in), .evt_valid(v3), .evt_ready(evt_ready),
    .ack_t(a3), .evt_count(c3), .overrun(o3), .clr_overrun(clr_overrun)
  );

  // Reference model: t_in as seen at each clock edge; an event is recognised
  // SYNC+1 edges after the line changes, then handled as a pending flag.
  logic samples[$];
  logic m_pend, m_ack, m_ovr;
  int   m_events;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples.delete();
      for (int i = 0; i < SYNC + 2; i++) samples.push_back(1'b0);
      m_pend = 1'b0; m_ack = 1'b0; m_ovr = 1'b0; m_events = 0;
    end else begin
      logic ev, hs;
      samples.push_front(t_in);
      ev = samples[SYNC] != samples[SYNC+1];
      void'(samples.pop_back());
      hs = m_pend && evt_ready;
      if (ev) m_events++;
      if (hs) m_ack = ~m_ack;
      m_ovr  = (m_pend && ev && !hs) || (m_ovr && !clr_overrun);
      m_pend = ev || (m_pend && !hs);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int v, input int a, input int o, input int cnt);
    chk({nm, ".valid8"}, int'(v8), v);
    chk({nm, ".ack8"},   int'(a8), a);
    chk({nm, ".ovr8"},   int'(o8), o);
    chk({nm, ".cnt8"},   int'(c8), (cnt > 255) ? 255 : cnt);
    chk({nm, ".valid3"}, int'(v3), v);
    chk({nm, ".ack3"},   int'(a3), a);
    chk({nm, ".ovr3"},   int'(o3), o);
    chk({nm, ".cnt3"},   int'(c3), (cnt > 7) ? 7 : cnt);
  endtask

  typedef struct {
    logic t, r, c;
    logic v, a, o;
    int   cnt;
  } vec_t;

  function automatic vec_t mk(logic t, logic r, logic c, logic v, logic a, logic o, int cnt);
    vec_t x;
    x.t = t; x.r = r; x.c = c; x.v = v; x.a = a; x.o = o; x.cnt = cnt;
    return x;
  endfunction

  vec_t tbl[35];

  initial begin
    // inputs for one cycle -> outputs after that cycle's rising edge
    tbl[0]  = mk(1,0,0, 0,0,0,0);  tbl[1]  = mk(1,0,0, 0,0,0,0);
    tbl[2]  = mk(1,0,0, 1,0,0,1);  tbl[3]  = mk(1,0,0, 1,0,0,1);
    tbl[4]  = mk(1,0,0, 1,0,0,1);  tbl[5]  = mk(1,0,0, 1,0,0,1);
    tbl[6]  = mk(1,0,0, 1,0,0,1);  tbl[7]  = mk(1,0,0, 1,0,0,1);
    tbl[8]  = mk(1,1,0, 0,1,0,1);  tbl[9]  = mk(1,0,0, 0,1,0,1);
    tbl[10] = mk(0,0,0, 0,1,0,1);  tbl[11] = mk(0,0,0, 0,1,0,1);
    tbl[12] = mk(0,0,0, 1,1,0,2);  tbl[13] = mk(0,0,0, 1,1,0,2);
    tbl[14] = mk(1,0,0, 1,1,0,2);  tbl[15] = mk(1,0,0, 1,1,0,2);
    tbl[16] = mk(1,0,0, 1,1,1,3);  tbl[17] = mk(1,1,0, 0,0,1,3);
    tbl[18] = mk(1,0,1, 0,0,0,3);  tbl[19] = mk(0,0,0, 0,0,0,3);
    tbl[20] = mk(0,0,0, 0,0,0,3);  tbl[21] = mk(0,0,0, 1,0,0,4);
    tbl[22] = mk(1,0,0, 1,0,0,4);  tbl[23] = mk(1,0,0, 1,0,0,4);
    tbl[24] = mk(1,1,0, 1,1,0,5);  tbl[25] = mk(1,1,0, 0,0,0,5);
    tbl[26] = mk(1,0,0, 0,0,0,5);  tbl[27] = mk(0,0,0, 0,0,0,5);
    tbl[28] = mk(0,0,0, 0,0,0,5);  tbl[29] = mk(0,0,0, 1,0,0,6);
    tbl[30] = mk(1,0,0, 1,0,0,6);  tbl[31] = mk(1,0,0, 1,0,0,6);
    tbl[32] = mk(1,0,1, 1,0,1,7);  tbl[33] = mk(1,0,1, 1,0,0,7);
    tbl[34] = mk(1,1,0, 0,1,0,7);

    repeat (3) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 35; i++) begin
      t_in = tbl[i].t; evt_ready = tbl[i].r; clr_overrun = tbl[i].c;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].a, tbl[i].o, tbl[i].cnt);
    end

    // saturation: ten toggles, each consumed
    rst_n = 1'b0; t_in = 1'b0; evt_ready = 1'b1; clr_overrun = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      t_in = ~t_in;
      repeat (5) @(negedge clk);
    end
    chk_all("sat", 0, 0, 0, 10);

    // reset between edges while an event is pending
    evt_ready = 1'b0; t_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_all("pre_rst", 1, 0, 0, 11);
    #2 rst_n = 1'b0;
    #1 chk_all("mid_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_all("rel_high", 1, 0, 0, 1);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk_all("one_evt", 0, 1, 0, 1);

    // random traffic against the model
    rst_n = 1'b0; t_in = 1'b0; evt_ready = 1'b0; clr_overrun = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) t_in = ~t_in;
      evt_ready   = ($urandom_range(0, 2) == 0);
      clr_overrun = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      chk_all("rand", int'(m_pend), int'(m_ack), int'(m_ovr), m_events);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
